// File: rtl/spi_ram_stream_writer.sv
// rtl/spi_ram_stream_writer.sv - byte stream to 32-bit RAM write initiator
//
// Purpose:
//   Drains a byte stream (SPI receive path) into a 32-bit single-port RAM.
//   Bytes are packed little-endian into words, and each word is issued as one
//   Avalon-MM write with a matching byteenable. A start/base/length
//   descriptor programs each transfer. The module reports busy, a one-cycle
//   done pulse, sticky overflow and a committed byte count.
//
// Optional build macro:
//   SPI_RAM_WRITER_WRAP_EN - when this macro is defined, a write to word
//   DEPTH-1 with bytes still remaining wraps the word address back to
//   base_addr. This turns [base_addr, DEPTH-1] into a circular buffer, and
//   overflow is never set.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   start             descriptor strobe (IDLE only)
//   base_addr         first word address, sampled on start
//   byte_count        bytes to transfer, sampled on start
//   abort             cancels a running transfer
//   in_data/in_valid/in_ready  byte stream
//   ram_address, ram_chipselect, ram_write, ram_byteenable, ram_writedata
//                     RAM s2 write port (fixed latency, no waitrequest)
//   busy              high while running
//   done              one-cycle completion pulse
//   overflow          sticky: RAM end reached with bytes remaining
//   bytes_written     bytes committed to RAM in the current/last transfer

module spi_ram_stream_writer #(
  parameter int ADDR_W  = 15,
  parameter int DEPTH   = 20480,
  parameter int COUNT_W = 17
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [COUNT_W-1:0] byte_count,
  input  logic               abort,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [ADDR_W-1:0]  ram_address,
  output logic               ram_chipselect,
  output logic               ram_write,
  output logic [3:0]         ram_byteenable,
  output logic [31:0]        ram_writedata,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [COUNT_W-1:0] bytes_written
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0]  r_word_addr;
  logic [COUNT_W-1:0] r_remaining;
  logic [1:0]         r_lane;
  logic [31:0]        r_acc_data;
  logic [3:0]         r_acc_be;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic               r_write;
  logic               r_done;
  logic               r_overflow;
  logic [COUNT_W-1:0] r_bytes_written;
`ifdef SPI_RAM_WRITER_WRAP_EN
  logic [ADDR_W-1:0]  r_base;
`endif

  logic               w_start_go;
  logic               w_zero_start;
  logic               w_accept;
  logic               w_last;
  logic               w_flush;
  logic               w_at_end;
  logic               w_end_hit;
  logic [ADDR_W-1:0]  w_next_addr;
  logic [31:0]        w_packed;
  logic [3:0]         w_be;
  logic [2:0]         w_pop;

  assign w_start_go   = (r_state == S_IDLE) && start && (byte_count != '0);
  assign w_zero_start = (r_state == S_IDLE) && start && (byte_count == '0);
  assign w_accept     = (r_state == S_RUN) && in_valid;
  assign w_last       = (r_remaining == COUNT_W'(1));
  // Abort wins over a same-cycle flush, so that byte is never written.
  assign w_flush      = w_accept && !abort && ((r_lane == 2'd3) || w_last);
  assign w_at_end     = (r_word_addr == ADDR_W'(DEPTH - 1));

  // Merge the incoming byte into the partial word so that a full word can be
  // registered in the same cycle that its last byte arrives.
  assign w_packed = r_acc_data | ({24'd0, in_data} << {r_lane, 3'b000});
  assign w_be     = r_acc_be | (4'b0001 << r_lane);
  assign w_pop    = 3'(r_be[0]) + 3'(r_be[1]) + 3'(r_be[2]) + 3'(r_be[3]);

`ifdef SPI_RAM_WRITER_WRAP_EN
  assign w_end_hit   = 1'b0;
  assign w_next_addr = w_at_end ? r_base : r_word_addr + ADDR_W'(1);
`else
  assign w_end_hit   = w_flush && w_at_end && !w_last;
  assign w_next_addr = r_word_addr + ADDR_W'(1);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    in_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_go) w_next = S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_flush && (w_last || w_end_hit)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word_addr     <= '0;
      r_remaining     <= '0;
      r_lane          <= '0;
      r_acc_data      <= '0;
      r_acc_be        <= '0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_be            <= '0;
      r_write         <= 1'b0;
      r_done          <= 1'b0;
      r_overflow      <= 1'b0;
      r_bytes_written <= '0;
`ifdef SPI_RAM_WRITER_WRAP_EN
      r_base          <= '0;
`endif
    end else begin
      r_write <= 1'b0;
      r_done  <= 1'b0;

      if (r_write) r_bytes_written <= r_bytes_written + COUNT_W'(w_pop);

      if (w_start_go) begin
        r_word_addr     <= base_addr;
        r_remaining     <= byte_count;
        r_lane          <= '0;
        r_acc_data      <= '0;
        r_acc_be        <= '0;
        r_overflow      <= 1'b0;
        r_bytes_written <= '0;
`ifdef SPI_RAM_WRITER_WRAP_EN
        r_base          <= base_addr;
`endif
      end

      if (w_zero_start || (r_state == S_DONE)) r_done <= 1'b1;

      if (r_state == S_RUN) begin
        if (abort) begin
          r_lane     <= '0;
          r_acc_data <= '0;
          r_acc_be   <= '0;
        end else if (w_accept) begin
          r_remaining <= r_remaining - COUNT_W'(1);
          r_lane      <= r_lane + 2'd1;
          if (w_flush) begin
            r_write     <= 1'b1;
            r_addr      <= r_word_addr;
            r_wdata     <= w_packed;
            r_be        <= w_be;
            r_acc_data  <= '0;
            r_acc_be    <= '0;
            r_word_addr <= w_next_addr;
            if (w_end_hit) r_overflow <= 1'b1;
          end else begin
            r_acc_data <= w_packed;
            r_acc_be   <= w_be;
          end
        end
      end
    end
  end

  assign ram_address    = r_addr;
  assign ram_chipselect = r_write;
  assign ram_write      = r_write;
  assign ram_byteenable = r_be;
  assign ram_writedata  = r_wdata;
  assign done           = r_done;
  assign overflow       = r_overflow;
  assign bytes_written  = r_bytes_written;

endmodule
